// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU, with a one-deep registered response slot.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_b1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_din1,
  output logic [31:0]      alu_din2,
  input  logic [31:0]      alu_dout,
  input  logic             alu_exc,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_exc,
  output logic [TAG_W-1:0] resp_tag
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [3:0] OP_IDLE = 4'b1110;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic [31:0]      data_q, data_d;
  logic             exc_q, exc_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             slot_free;
  logic             gnt_any;
  logic             gnt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      data_q    <= '0;
      exc_q     <= 1'b0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      data_q    <= data_d;
      exc_q     <= exc_d;
      tag_q     <= tag_d;
    end
  end

  // Grant is also blocked during reset so an in-flight request is never accepted.
  always_comb begin
    slot_free = (state_q == EMPTY) | resp_ready[owner_q];
    gnt_any   = slot_free & (|req_valid) & ~rst;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_idx = 1'b0;
`else
      gnt_idx = ~rr_last_q;
`endif
    end else begin
      gnt_idx = req_valid[1];
    end

    req_ready = '0;
    alu_op    = OP_IDLE;
    alu_din1  = '0;
    alu_din2  = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
      alu_op   = gnt_idx ? req_op1 : req_op0;
      alu_din1 = gnt_idx ? req_a1  : req_a0;
      alu_din2 = gnt_idx ? req_b1  : req_b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    data_d    = data_q;
    exc_d     = exc_q;
    tag_d     = tag_q;
    if (gnt_any) begin
      // A grant always refills the slot, covering the drain-and-refill case.
      state_d   = FULL;
      owner_d   = gnt_idx;
      rr_last_d = gnt_idx;
      data_d    = alu_exc ? '0 : alu_dout;
      exc_d     = alu_exc;
      tag_d     = gnt_idx ? req_tag1 : req_tag0;
    end else if (state_q == FULL && resp_ready[owner_q]) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == FULL) resp_valid[owner_q] = 1'b1;
  end

  assign resp_data = data_q;
  assign resp_exc  = exc_q;
  assign resp_tag  = tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; includes a small reference ALU model.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [3:0]  req_tag0, req_tag1;
  logic [3:0]  alu_op;
  logic [31:0] alu_din1, alu_din2, alu_dout;
  logic        alu_exc;
  logic [1:0]  resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic [3:0]  resp_tag;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .alu_op(alu_op), .alu_din1(alu_din1), .alu_din2(alu_din2),
    .alu_dout(alu_dout), .alu_exc(alu_exc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_exc(resp_exc), .resp_tag(resp_tag)
  );

  // Reference ALU: 0000 add (trap on signed overflow, garbage result), 0001 addu, 0110 sll.
  logic [31:0] add_sum;
  assign add_sum = alu_din1 + alu_din2;
  always_comb begin
    alu_dout = '0;
    alu_exc  = 1'b0;
    case (alu_op)
      4'b0000: begin
        alu_exc  = (alu_din1[31] == alu_din2[31]) && (add_sum[31] != alu_din1[31]);
        alu_dout = alu_exc ? 32'hDEADBEEF : add_sum;
      end
      4'b0001: alu_dout = add_sum;
      4'b0110: alu_dout = alu_din2 << alu_din1[4:0];
      default: alu_dout = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total_cnt++; if (resp_valid !== 2'b00) $display("FAIL reset_rv got %b want 00", resp_valid); else pass_cnt++;
    total_cnt++; if (resp_data !== 32'd0) $display("FAIL reset_data got %h want 0", resp_data); else pass_cnt++;
    total_cnt++; if (resp_exc !== 1'b0) $display("FAIL reset_exc got %b want 0", resp_exc); else pass_cnt++;
    total_cnt++; if (resp_tag !== 4'd0) $display("FAIL reset_tag got %h want 0", resp_tag); else pass_cnt++;
    total_cnt++; if (alu_op !== 4'b1110) $display("FAIL idle_op got %b want 1110", alu_op); else pass_cnt++;
    total_cnt++; if (alu_din1 !== 32'd0 || alu_din2 !== 32'd0) $display("FAIL idle_din got %h/%h want 0/0", alu_din1, alu_din2); else pass_cnt++;
  endtask

  task automatic test_single();
    tick();
    req_valid = 2'b01; req_op0 = 4'b0001; req_a0 = 32'd5; req_b0 = 32'd7; req_tag0 = 4'd3;
    resp_ready = 2'b01;
    @(negedge clk);
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready); else pass_cnt++;
    total_cnt++; if (alu_op !== 4'b0001 || alu_din1 !== 32'd5 || alu_din2 !== 32'd7)
      $display("FAIL single_drive got %b/%h/%h want 0001/5/7", alu_op, alu_din1, alu_din2); else pass_cnt++;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    total_cnt++; if (resp_valid !== 2'b01) $display("FAIL single_rv got %b want 01", resp_valid); else pass_cnt++;
    total_cnt++; if (resp_data !== 32'd12) $display("FAIL single_data got %0d want 12", resp_data); else pass_cnt++;
    total_cnt++; if (resp_exc !== 1'b0 || resp_tag !== 4'd3) $display("FAIL single_exc_tag got %b/%h want 0/3", resp_exc, resp_tag); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (resp_valid !== 2'b00) $display("FAIL single_drain got %b want 00", resp_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    tick();
    req_valid = 2'b01; req_op0 = 4'b0000; req_a0 = 32'h7FFFFFFF; req_b0 = 32'd1; req_tag0 = 4'd5;
    resp_ready = 2'b01;
    tick();
    req_op0 = 4'b0001; req_tag0 = 4'd6;
    @(negedge clk);
    total_cnt++; if (resp_exc !== 1'b1) $display("FAIL ovf_exc got %b want 1", resp_exc); else pass_cnt++;
    total_cnt++; if (resp_data !== 32'd0) $display("FAIL ovf_data got %h want 0", resp_data); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL ovf_refill_ready got %b want 01", req_ready); else pass_cnt++;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    total_cnt++; if (resp_data !== 32'h80000000 || resp_exc !== 1'b0)
      $display("FAIL addu_wrap got %h/%b want 80000000/0", resp_data, resp_exc); else pass_cnt++;
    total_cnt++; if (resp_tag !== 4'd6 || resp_valid !== 2'b01) $display("FAIL addu_tag got %h/%b want 6/01", resp_tag, resp_valid); else pass_cnt++;
    tick();
    drive_idle();
  endtask

  task automatic test_ties();
    int prev;
    int gi;
    apply_reset();
    req_valid = 2'b11; resp_ready = 2'b11;
    req_op0 = 4'b0001; req_a0 = 32'd10; req_b0 = 32'd0; req_tag0 = 4'd0;
    req_op1 = 4'b0001; req_a1 = 32'd20; req_b1 = 32'd0; req_tag1 = 4'd1;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      gi = FIXED ? 0 : (i % 2);
      @(negedge clk);
      total_cnt++; if (req_ready !== (2'b01 << gi)) $display("FAIL tie_grant%0d got %b want %b", i, req_ready, 2'b01 << gi); else pass_cnt++;
      total_cnt++; if (alu_din1 !== (gi == 1 ? 32'd20 : 32'd10)) $display("FAIL tie_din%0d got %0d", i, alu_din1); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (resp_valid !== (2'b01 << prev) || resp_tag !== prev[3:0])
          $display("FAIL tie_resp%0d got %b/%h want %b/%0d", i, resp_valid, resp_tag, 2'b01 << prev, prev); else pass_cnt++;
      end
      prev = gi;
      tick();
    end
    req_valid = 2'b10;
    @(negedge clk);
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL tie_release got %b want 10", req_ready); else pass_cnt++;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 2'b01; resp_ready = 2'b00;
    req_op0 = 4'b0001; req_a0 = 32'd1; req_b0 = 32'd1; req_tag0 = 4'd2;
    req_op1 = 4'b0001; req_a1 = 32'd100; req_b1 = 32'd1; req_tag1 = 4'd9;
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (req_ready !== 2'b00) $display("FAIL stall_ready%0d got %b want 00", i, req_ready); else pass_cnt++;
      total_cnt++; if (alu_op !== 4'b1110 || alu_din1 !== 32'd0) $display("FAIL stall_alu%0d got %b/%h want 1110/0", i, alu_op, alu_din1); else pass_cnt++;
      total_cnt++; if (resp_valid !== 2'b01 || resp_data !== 32'd2 || resp_tag !== 4'd2)
        $display("FAIL stall_resp%0d got %b/%0d/%h want 01/2/2", i, resp_valid, resp_data, resp_tag); else pass_cnt++;
      tick();
    end
    resp_ready = 2'b01;
    @(negedge clk);
    total_cnt++; if (req_ready !== (FIXED ? 2'b01 : 2'b10)) $display("FAIL unstall_grant got %b", req_ready); else pass_cnt++;
    tick();
    req_valid = 2'b00; resp_ready = 2'b00;
    @(negedge clk);
    total_cnt++; if (resp_valid !== (FIXED ? 2'b01 : 2'b10)) $display("FAIL unstall_rv got %b", resp_valid); else pass_cnt++;
    total_cnt++; if (resp_data !== (FIXED ? 32'd2 : 32'd101)) $display("FAIL unstall_data got %0d", resp_data); else pass_cnt++;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_d;
    tick();
    req_valid = 2'b10; resp_ready = 2'b10;
    req_op1 = 4'b0110; req_a1 = 32'd4; req_tag1 = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) req_b1 = i; else req_valid = 2'b00;
      @(negedge clk);
      if (i <= 3) begin
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL b2b_ready%0d got %b want 10", i, req_ready); else pass_cnt++;
      end
      if (i >= 2) begin
        exp_d = 16 * (i - 1);
        total_cnt++; if (resp_valid !== 2'b10 || resp_data !== exp_d)
          $display("FAIL b2b_data%0d got %b/%0d want 10/%0d", i, resp_valid, resp_data, exp_d); else pass_cnt++;
      end
      tick();
    end
    @(negedge clk);
    total_cnt++; if (resp_valid !== 2'b00) $display("FAIL b2b_drain got %b want 00", resp_valid); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_reset_mid_op();
    tick();
    req_valid = 2'b01; resp_ready = 2'b00;
    req_op0 = 4'b0001; req_a0 = 32'd3; req_b0 = 32'd4; req_tag0 = 4'd7;
    tick();
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    total_cnt++; if (resp_valid !== 2'b01 || resp_data !== 32'd7) $display("FAIL mid_full got %b/%0d want 01/7", resp_valid, resp_data); else pass_cnt++;
    tick();
    resp_ready = 2'b11;
    @(negedge clk);
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL mid_rst_ready got %b want 00", req_ready); else pass_cnt++;
    total_cnt++; if (resp_valid !== 2'b00 || resp_data !== 32'd0 || resp_tag !== 4'd0)
      $display("FAIL mid_rst_resp got %b/%h/%h want 00/0/0", resp_valid, resp_data, resp_tag); else pass_cnt++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL mid_first_tie got %b want 01", req_ready); else pass_cnt++;
    tick();
    drive_idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b11;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0;
    req_b0 = '0; req_b1 = '0; req_tag0 = '0; req_tag1 = '0;
    test_reset();
    test_single();
    test_overflow();
    test_ties();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU datapath instance between two requesters, e.g. an execute stage and a multi-cycle address/branch helper.
- Arbitrates per cycle and drives the ALU operand/opcode inputs combinationally from the granted request.
- Registers the ALU result, overflow-exception flag and tag into a one-deep response slot.
- Returns the response to the owning requester over a valid/ready handshake; throughput is one op per cycle when responses drain immediately.

Parameters:
- TAG_W, 4, width of the opaque request tag echoed back with the response.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  2  per-requester request valid; bit i = requester i.
- req_ready  output  2  per-requester request accepted this cycle.
- req_op0, req_op1  input  4 each  ALU opcode for requester 0/1.
- req_a0, req_a1  input  32 each  first operand (din1 role; shift amount in [4:0]).
- req_b0, req_b1  input  32 each  second operand (din2 role).
- req_tag0, req_tag1  input  TAG_W each  request tag.
- alu_op  output  4  to ALU aluOp.
- alu_din1  output  32  to ALU din1.
- alu_din2  output  32  to ALU din2.
- alu_dout  input  32  from ALU dout.
- alu_exc  input  1  from ALU exception.
- resp_valid  output  2  response valid; at most one bit set.
- resp_ready  input  2  per-requester response accept.
- resp_data  output  32  registered result.
- resp_exc  output  1  registered overflow exception.
- resp_tag  output  TAG_W  registered tag of the response.

Behaviour:
- Reset: resp_valid=0, resp_data=0, resp_exc=0, resp_tag=0, owner=0, rr_last=1 (requester 0 wins first tie), state=EMPTY.
- States:
  - EMPTY: no held response.
  - FULL: response held in slot; owner register names the requester.
- slot_free = (state==EMPTY) | (state==FULL & resp_ready[owner]).
- Grant:
  - Only when slot_free and any req_valid.
  - Single valid: that requester wins.
  - Both valid: the requester != rr_last wins (round-robin).
  - req_ready = one-hot grant; combinational, same cycle.
- ALU drive:
  - Granted: alu_op/alu_din1/alu_din2 = granted op/a/b.
  - No grant: alu_op=4'b1110 (exception-suppressed code), alu_din1=alu_din2=0.
- Capture on a grant edge:
  - resp_data = alu_exc ? 0 : alu_dout, so X from the ALU never reaches a requester.
  - resp_exc = alu_exc; resp_tag = granted tag; owner = granted index; rr_last = granted index; state=FULL.
- Drain:
  - FULL with resp_ready[owner]=1 and no new grant → EMPTY, resp_valid=0.
  - Drain plus new grant in the same cycle → stays FULL with the new result; back-to-back, no bubble.
- resp_valid[i] = (state==FULL) & (owner==i); resp_ready of the non-owner is ignored.
- Latency: accepted at edge N, resp_valid high after edge N (visible in cycle N+1).
- Requester rules: must hold op/a/b/tag stable while req_valid & !req_ready; may drop req_valid without acceptance (no penalty, rr_last unchanged).
- Response slot stalled (FULL, owner not ready) → req_ready=0 for both; ALU driven with the idle values.
- rr_last updates only on an accepted grant, never on a stall.
- Mid-operation rst: the held response is discarded; all outputs return to reset values at the next edge; in-flight request not accepted.
- Opcodes pass through unchecked; an unsupported opcode captures whatever the ALU returns (0 substituted only when alu_exc=1).

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; rr_last is not used for arbitration (still updated on grant, for observability).
- Not defined: round-robin as above.

Test Plan:
- Single op: req_valid=01, op=0001, a=5, b=7, tag=3 → req_ready=01 same cycle; next cycle resp_valid=01, resp_data=12, resp_exc=0, resp_tag=3.
- Overflow: op=0000, a=0x7FFFFFFF, b=1 → resp_exc=1, resp_data=0; with op=0001 same operands → resp_data=0x80000000, resp_exc=0.
- Ties, both valid with ready held high for 4 cycles: grants 0,1,0,1 (round-robin); with ALU_ARB_FIXED_PRIO_EN, grants 0,0,0,0 and requester 1 starves until req_valid[0] drops.
- Backpressure: resp_ready[0]=0 for 3 cycles with req_valid=11 → req_ready=00, alu_op=1110, resp stable; raise resp_ready[0] → same cycle grants requester 1; next cycle resp_valid=10.
- Back-to-back: requester 1 streams sll ops with shift a=4, b=1,2,3 and resp_ready=1 → results 16,32,48 on consecutive cycles, no bubble.
- Reset mid-op: assert rst while FULL → next cycle resp_valid=00, resp_data=0; first tie after release grants requester 0.
